// File: rtl/sequencer_adcscan.sv
// ADC scan sequencer: walks a static list of channels, issues one command per
// enabled entry, waits for the matching result (or a timeout) and loops while enabled.
module sequencer_adcscan #(
    parameter int SCAN_LEN     = 4,
    parameter int TIMEOUT_CLKS = 255
) (
    input  logic                  CLOCK,
    input  logic                  RESET_N,
    input  logic                  ENABLE,
    input  logic [SCAN_LEN*5-1:0] SCAN_LIST,
    input  logic                  ERR_CLR,
    output logic                  cmd_valid,
    output logic [4:0]            cmd_channel,
    output logic                  cmd_sop,
    output logic                  cmd_eop,
    input  logic                  cmd_ready,
    input  logic                  rsp_valid,
    input  logic [4:0]            rsp_channel,
    output logic                  BUSY,
    output logic                  SCAN_DONE,
    output logic                  TIMEOUT_ERR,
    output logic [4:0]            ERR_CHAN
);

    localparam int               CNT_W    = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [4:0]       LAST_IDX = 5'(SCAN_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CLKS - 1);
    localparam logic [4:0]       DISABLED = 5'd31;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_RSP = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [4:0]       idx_r;
    logic [4:0]       idx_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;
    logic [4:0]       entry_tab [32];
    logic [4:0]       cur_entry_s;
    logic [4:0]       nxt_entry_s;
    logic             complete_s;
    logic             timeout_s;
    logic             done_s;
    logic             issue_s;

    // Slots beyond SCAN_LEN read as disabled so idx can index a fixed table.
    genvar k;
    generate
        for (k = 0; k < 32; k++) begin : g_entry
            if (k < SCAN_LEN) begin : g_used
                assign entry_tab[k] = SCAN_LIST[5*k +: 5];
            end else begin : g_unused
                assign entry_tab[k] = DISABLED;
            end
        end
    endgenerate

    assign cur_entry_s = entry_tab[idx_r];
    assign nxt_entry_s = entry_tab[idx_s];
    assign issue_s     = (state_s == ISSUE) && (nxt_entry_s != DISABLED);

    // Next state, index and wait counter; completion decides scan wrap or early stop.
    always_comb begin
        state_s    = state_r;
        idx_s      = idx_r;
        cnt_s      = cnt_r;
        complete_s = 1'b0;
        timeout_s  = 1'b0;
        done_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (ENABLE) begin
                    state_s = ISSUE;
                    idx_s   = 5'd0;
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE: begin
                if (cur_entry_s == DISABLED) begin
                    complete_s = 1'b1;
                end else if (cmd_valid && cmd_ready) begin
                    state_s = WAIT_RSP;
                    cnt_s   = {CNT_W{1'b0}};
                end else begin
                    state_s = ISSUE;
                end
            end
            WAIT_RSP: begin
                if (rsp_valid && (rsp_channel == cur_entry_s)) begin
                    complete_s = 1'b1;
                end else if (cnt_r == CNT_LAST) begin
                    cnt_s      = cnt_r + CNT_W'(1);
                    timeout_s  = 1'b1;
                    complete_s = 1'b1;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            default: begin
                state_s = IDLE;
                idx_s   = 5'd0;
            end
        endcase

        if (complete_s) begin
            if (idx_r == LAST_IDX) begin
                done_s  = 1'b1;
                idx_s   = 5'd0;
                state_s = ENABLE ? ISSUE : IDLE;
            end else if (ENABLE) begin
                idx_s   = idx_r + 5'd1;
                state_s = ISSUE;
            end else begin
                idx_s   = 5'd0;
                state_s = IDLE;
            end
        end else begin
            done_s = 1'b0;
        end
    end

    // State registers; command outputs are registered decodes of the next state and index.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_r     <= IDLE;
            idx_r       <= 5'd0;
            cnt_r       <= {CNT_W{1'b0}};
            cmd_valid   <= 1'b0;
            cmd_channel <= 5'd0;
            cmd_sop     <= 1'b0;
            cmd_eop     <= 1'b0;
            BUSY        <= 1'b0;
            SCAN_DONE   <= 1'b0;
            TIMEOUT_ERR <= 1'b0;
            ERR_CHAN    <= 5'd0;
        end else begin
            state_r     <= state_s;
            idx_r       <= idx_s;
            cnt_r       <= cnt_s;
            cmd_valid   <= issue_s;
            cmd_channel <= issue_s ? nxt_entry_s : 5'd0;
            cmd_sop     <= issue_s && (idx_s == 5'd0);
            cmd_eop     <= issue_s && (idx_s == LAST_IDX);
            BUSY        <= (state_s != IDLE);
            SCAN_DONE   <= done_s;
            // A timeout outranks a coincident clear.
            if (timeout_s) begin
                TIMEOUT_ERR <= 1'b1;
                ERR_CHAN    <= cur_entry_s;
            end else if (ERR_CLR) begin
                TIMEOUT_ERR <= 1'b0;
                ERR_CHAN    <= ERR_CHAN;
            end else begin
                TIMEOUT_ERR <= TIMEOUT_ERR;
                ERR_CHAN    <= ERR_CHAN;
            end
        end
    end

endmodule

// File: doc/sequencer_adcscan.md
SEQUENCER_ADCSCAN -- requirements
Module: sequencer_adcscan

Interface
REQ-001 Parameter SCAN_LEN, default 4: number of scan-list entries, range 1-32.
REQ-002 Parameter TIMEOUT_CLKS, default 255: cycles to wait for a conversion result before declaring a timeout, range 1 or more.
REQ-003 CLOCK  in  1  system clock; all logic on the rising edge.
REQ-004 RESET_N  in  1  asynchronous, active-low reset.
REQ-005 ENABLE  in  1  level; high requests continuous scanning.
REQ-006 SCAN_LIST  in  SCAN_LEN*5  static config; entry k = bits [5k+4:5k] = ADC channel; value 5'd31 = disabled entry.
REQ-007 ERR_CLR  in  1  pulse; clears TIMEOUT_ERR.
REQ-008 cmd_valid  out  1  ADC command valid.
REQ-009 cmd_channel  out  5  ADC command channel.
REQ-010 cmd_sop / cmd_eop  out  1 each  first / last entry of the scan.
REQ-011 cmd_ready  in  1  ADC accepts the command.
REQ-012 rsp_valid  in  1  ADC result valid.
REQ-013 rsp_channel  in  5  channel of the ADC result; data is consumed elsewhere.
REQ-014 BUSY  out  1  high whenever the FSM is not in IDLE.
REQ-015 SCAN_DONE  out  1  one-cycle pulse at the end of each scan.
REQ-016 TIMEOUT_ERR  out  1  sticky timeout flag.
REQ-017 ERR_CHAN  out  5  channel of the most recent timeout.

Function
REQ-018 FSM states are IDLE, ISSUE and WAIT_RSP, plus a 5-bit entry index idx and a timeout counter sized clog2(TIMEOUT_CLKS+1).
- REQ-019 IDLE, ENABLE high: go to ISSUE with idx=0 next cycle.
- IDLE, ENABLE low: stay in IDLE.
REQ-020 In ISSUE with entry[idx]!=31:
- cmd_valid=1, cmd_channel=entry[idx].
- cmd_sop=(idx==0), cmd_eop=(idx==SCAN_LEN-1).
- All four outputs are decoded from registered state and idx.
REQ-021 cmd_valid stays high with a stable channel until cmd_valid&&cmd_ready; it is never withdrawn, even if ENABLE falls.
REQ-022 On the handshake: go to WAIT_RSP and clear the timeout counter.
REQ-023 In ISSUE with entry[idx]==31:
- cmd_valid stays low for one cycle.
- The entry is treated as complete (REQ-026).
- sop/eop are not moved to another entry.
REQ-024 In WAIT_RSP:
- rsp_valid with rsp_channel==entry[idx] completes the entry.
- A mismatched rsp_valid is ignored.
- rsp_valid outside WAIT_RSP is ignored.
REQ-025 In WAIT_RSP, the counter increments each cycle without a match. When it reaches TIMEOUT_CLKS:
- TIMEOUT_ERR is set.
- ERR_CHAN is set to entry[idx].
- The entry completes.
REQ-026 Entry completion:
- If idx<SCAN_LEN-1: idx+1, go to ISSUE.
- Else: SCAN_DONE pulses on the next cycle; idx=0; go to ISSUE if ENABLE is high, else IDLE.
REQ-027 If ENABLE falls mid-scan, the in-flight command finishes its handshake and response/timeout, then the FSM goes to IDLE with no SCAN_DONE.
REQ-028 A timeout and ERR_CLR in the same cycle leave TIMEOUT_ERR set; ERR_CLR alone clears it next cycle; ERR_CHAN holds its value.
REQ-029 Latency:
- ENABLE rising in IDLE gives cmd_valid 1 cycle later.
- A matching rsp gives the next cmd_valid 1 cycle later.
- The last entry's response gives SCAN_DONE 1 cycle later.
REQ-030 With all entries disabled, each scan takes SCAN_LEN cycles and SCAN_DONE pulses every SCAN_LEN cycles while ENABLE is high.

Reset
REQ-031 While RESET_N is low, regardless of CLOCK:
- State is IDLE, idx=0, counter=0.
- cmd_valid, cmd_sop, cmd_eop, BUSY, SCAN_DONE and TIMEOUT_ERR are 0.
- cmd_channel=0 and ERR_CHAN=0.
REQ-032 Reset asserted mid-handshake drops cmd_valid immediately; after release, scanning restarts from idx=0.

Verification
REQ-033 SCAN_LIST={3,2,1,0}, cmd_ready=1, rsp 2 cycles after each command:
- Commands appear on channels 0,1,2,3.
- sop is set with ch0, eop with ch3.
- One SCAN_DONE per scan, then the scan repeats.
REQ-034 cmd_ready held low for 10 cycles:
- cmd_valid stays high with a constant channel.
- Exactly one command is accepted when ready rises.
REQ-035 TIMEOUT_CLKS=8, no rsp on ch2:
- TIMEOUT_ERR=1 and ERR_CHAN=2 after 8 wait cycles.
- The scan continues to ch3.
- ERR_CLR with a coincident timeout keeps the flag set.
REQ-036 Entry 1=31:
- No command for that slot; it costs 1 cycle.
- SCAN_DONE still occurs.
- Mismatched rsp_channel=7 during a wait is ignored.
REQ-037 ENABLE drops while waiting on entry 1:
- The response completes, the FSM enters IDLE, BUSY=0, no SCAN_DONE.
- Then RESET_N pulses mid-command: all outputs are 0 and the next scan starts at idx 0.
